// File: rtl/fetch_stage_if.sv
// fetch_stage_if: split-handshake instruction-memory port.
//   inst_req      fetch request valid              (master -> slave)
//   inst_addr     fetch address, ADDR_W bits       (master -> slave)
//   inst_addr_ok  slave accepted the request       (slave -> master)
//   inst_data_ok  read data valid, one per accept  (slave -> master)
//   inst_rdata    read data, 32 bits               (slave -> master)
// The fetch stage uses the master modport; the memory uses the slave modport.
interface fetch_stage_if #(
    parameter int ADDR_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [31:0]       inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage MIPS pipeline.
// Owns the PC and keeps exactly one fetch outstanding on the instruction
// memory port. The returned word is buffered for D and held while stallF is
// high. Branch/jump redirects from D replace the PC; a fetch already accepted
// by memory when a redirect lands is marked stale and its word is dropped.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   stallF          hold PC and buffer (also blocks redirects)
//   pcsrcD/pcbranchD  taken branch and its target
//   jumpD/pcjumpD     jump / jr and its target (wins over a branch)
//   imem            instruction memory port (fetch_stage_if.master)
//   pcF, pcplus4F   PC of the buffered instruction and PC+4
//   instrF          buffered instruction, 0 (NOP) when not valid
//   instr_validF    instrF is valid
//   fetch_busyF     no instruction available yet
//   fetch_wait_cnt  cycles spent in REQ/WAIT (saturating)
//
// Build option: define FETCH_PERF_CNT_EN to enable the fetch_wait_cnt counter;
// without it the output is tied to zero and no counter flops exist.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallF,
    input  logic              pcsrcD,
    input  logic [ADDR_W-1:0] pcbranchD,
    input  logic              jumpD,
    input  logic [ADDR_W-1:0] pcjumpD,
    fetch_stage_if.master     imem,
    output logic [ADDR_W-1:0] pcF,
    output logic [ADDR_W-1:0] pcplus4F,
    output logic [31:0]       instrF,
    output logic              instr_validF,
    output logic              fetch_busyF,
    output logic [31:0]       fetch_wait_cnt
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // presenting the address, waiting for addr_ok
        S_WAIT = 2'd1,  // request accepted, waiting for data_ok
        S_HOLD = 2'd2   // word buffered, waiting for D to consume it
    } fetchState_e;

    fetchState_e       stateReg, stateNext;
    logic [ADDR_W-1:0] pcReg, pcNext;
    logic [31:0]       bufReg, bufNext;
    logic              discardReg, discardNext;  // in-flight fetch is stale

    logic              redirect;
    logic [ADDR_W-1:0] target;

    assign redirect = (pcsrcD | jumpD) & ~stallF;
    assign target   = jumpD ? pcjumpD : pcbranchD;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= S_REQ;
            pcReg      <= RESET_PC;
            bufReg     <= 32'h0;
            discardReg <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            pcReg      <= pcNext;
            bufReg     <= bufNext;
            discardReg <= discardNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext   = stateReg;
        pcNext      = pcReg;
        bufNext     = bufReg;
        discardNext = discardReg;
        case (stateReg)
            S_REQ: begin
                // An unaccepted address is simply replaced by the new PC next cycle.
                if (redirect) begin
                    pcNext = target;
                end
                if (imem.inst_addr_ok) begin
                    stateNext = S_WAIT;
                    if (redirect) begin
                        discardNext = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pcNext = target;
                end
                if (imem.inst_data_ok) begin
                    if (discardReg || redirect) begin
                        discardNext = 1'b0;
                        stateNext   = S_REQ;
                    end else begin
                        bufNext   = imem.inst_rdata;
                        stateNext = S_HOLD;
                    end
                end else if (redirect) begin
                    discardNext = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pcNext    = target;
                    stateNext = S_REQ;
                end else if (!stallF) begin
                    pcNext    = pcReg + ADDR_W'(4);
                    stateNext = S_REQ;
                end
            end
            default: begin
                stateNext = S_REQ;
            end
        endcase
    end

    // Outputs
    always_comb begin
        imem.inst_req  = (stateReg == S_REQ) && !rst;
        imem.inst_addr = pcReg;
        instr_validF   = (stateReg == S_HOLD);
        instrF         = instr_validF ? bufReg : 32'h0;
        fetch_busyF    = !instr_validF;
    end

    assign pcF      = pcReg;
    assign pcplus4F = pcReg + ADDR_W'(4);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] waitCntReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            waitCntReg <= 32'h0;
        end else if ((stateReg == S_REQ || stateReg == S_WAIT) &&
                     waitCntReg != 32'hFFFF_FFFF) begin
            waitCntReg <= waitCntReg + 32'd1;
        end
    end

    assign fetch_wait_cnt = waitCntReg;
`else
    assign fetch_wait_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stallF = 1'b0, pcsrcD = 1'b0, jumpD = 1'b0;
    logic [31:0] pcbranchD = 32'h0, pcjumpD = 32'h0;
    logic [31:0] pcF, pcplus4F, instrF, fetchWaitCnt;
    logic        instr_validF, fetch_busyF;

    fetch_stage_if #(.ADDR_W(ADDR_W)) imem ();

    fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallF         (stallF),
        .pcsrcD         (pcsrcD),
        .pcbranchD      (pcbranchD),
        .jumpD          (jumpD),
        .pcjumpD        (pcjumpD),
        .imem           (imem),
        .pcF            (pcF),
        .pcplus4F       (pcplus4F),
        .instrF         (instrF),
        .instr_validF   (instr_validF),
        .fetch_busyF    (fetch_busyF),
        .fetch_wait_cnt (fetchWaitCnt)
    );

    int compareCnt  = 0;
    int mismatchCnt = 0;

    // Reference model: transaction-level view of the fetch stage.
    logic [31:0] expPc = RESET_PC, expInstr = 32'h0, outAddr = 32'h0;
    bit          expValid = 1'b0, outstanding = 1'b0, outStale = 1'b0;
    bit          modelLive = 1'b0, rstCur = 1'b1;
    logic [31:0] expCnt = 32'h0;

    // Memory responder state and latency knobs.
    bit          memPending = 1'b0;
    logic [31:0] memAddr = 32'h0;
    int          memAccCnt = -1, memDataCnt = 0;
    int          addrLo = 0, addrHi = 0, dataLo = 0, dataHi = 0;
    bit          lastAddrOk = 1'b0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCnt++;
        if (obs !== exp) begin
            mismatchCnt++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: check what the DUT shows now, then drive this cycle's inputs
    // and advance the model to what the next clock edge should produce.
    task automatic step(input bit r, input bit s, input bit ps, input bit j,
                        input logic [31:0] bt, input logic [31:0] jt);
        bit          redir, consume, wasValid, wasOut, expReq;
        logic [31:0] tgt;
        @(negedge clk);
        if (modelLive) begin
            expReq = !rstCur && !expValid && !outstanding;
            checkVal("inst_req", 32'(imem.inst_req), 32'(expReq));
            if (expReq) checkVal("inst_addr", imem.inst_addr, expPc);
            checkVal("pcF", pcF, expPc);
            checkVal("pcplus4F", pcplus4F, expPc + 32'd4);
            checkVal("instr_validF", 32'(instr_validF), 32'(expValid));
            checkVal("instrF", instrF, expValid ? expInstr : 32'h0);
            checkVal("fetch_busyF", 32'(fetch_busyF), 32'(!expValid));
`ifdef FETCH_PERF_CNT_EN
            checkVal("fetch_wait_cnt", fetchWaitCnt, expCnt);
`else
            checkVal("fetch_wait_cnt", fetchWaitCnt, 32'h0);
`endif
        end

        rst = r; stallF = s; pcsrcD = ps; jumpD = j; pcbranchD = bt; pcjumpD = jt;

        imem.inst_addr_ok = 1'b0;
        imem.inst_data_ok = 1'b0;
        imem.inst_rdata   = $urandom;
        lastAddrOk        = 1'b0;
        if (r) begin
            memPending = 1'b0;
            memAccCnt  = -1;
        end else if (memPending) begin
            if (memDataCnt == 0) begin
                imem.inst_data_ok = 1'b1;
                imem.inst_rdata   = memWord(memAddr);
                memPending        = 1'b0;
            end else begin
                memDataCnt--;
            end
        end else if (imem.inst_req === 1'b1) begin
            if (memAccCnt < 0) memAccCnt = $urandom_range(addrHi, addrLo);
            if (memAccCnt == 0) begin
                imem.inst_addr_ok = 1'b1;
                lastAddrOk        = 1'b1;
                memPending        = 1'b1;
                memAddr           = imem.inst_addr;
                memDataCnt        = $urandom_range(dataHi, dataLo);
                memAccCnt         = -1;
            end else begin
                memAccCnt--;
            end
        end

        if (r) begin
            if (!rstCur) $display("[%0t] reset", $time);
            expPc = RESET_PC; expValid = 1'b0; expInstr = 32'h0;
            outstanding = 1'b0; outStale = 1'b0; expCnt = 32'h0; modelLive = 1'b1;
        end else begin
            redir    = (ps | j) & !s;
            tgt      = j ? jt : bt;
            wasValid = expValid;
            wasOut   = outstanding;
            consume  = wasValid && !s;
            if (!wasValid && expCnt != 32'hFFFF_FFFF) expCnt++;
            if (!wasValid && !wasOut) begin
                if (imem.inst_addr_ok) begin
                    outstanding = 1'b1;
                    outAddr     = expPc;
                    outStale    = redir;
                end
            end else if (wasOut) begin
                if (imem.inst_data_ok) begin
                    outstanding = 1'b0;
                    if (outStale || redir) begin
                        $display("[%0t] drop stale addr=%h", $time, outAddr);
                    end else begin
                        expValid = 1'b1;
                        expInstr = memWord(outAddr);
                    end
                end else if (redir) begin
                    outStale = 1'b1;
                end
            end
            if (wasValid && consume && !redir)
                $display("[%0t] consume pc=%h instr=%h", $time, expPc, expInstr);
            if (redir) $display("[%0t] redirect to %h", $time, tgt);
            if (wasValid && (redir || consume)) expValid = 1'b0;
            if (redir)        expPc = tgt;
            else if (consume) expPc = expPc + 32'd4;
        end
        rstCur = r;
    endtask

    task automatic stepIdle(input bit s);
        step(1'b0, s, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Step with stall held until a buffered word is visible (at least one step).
    task automatic waitValid(input string tag, input int limit);
        int n = 0;
        do begin
            stepIdle(1'b1);
            n++;
        end while (instr_validF !== 1'b1 && n < limit);
        checkVal(tag, 32'(instr_validF), 32'd1);
    endtask

    logic [31:0] c0;
    logic [31:0] tgtA, tgtB;
    int          n;
    bit          sawValid;

    initial begin
        imem.inst_addr_ok = 1'b0;
        imem.inst_data_ok = 1'b0;
        imem.inst_rdata   = 32'h0;

        // Reset for two cycles with zero-latency memory.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        stepIdle(1'b1);
        checkVal("reset pcF", pcF, RESET_PC);
        checkVal("reset valid", 32'(instr_validF), 32'd0);
        checkVal("reset req", 32'(imem.inst_req), 32'd0);
        stepIdle(1'b1);
        checkVal("first req", 32'(imem.inst_req), 32'd1);
        checkVal("first addr", imem.inst_addr, RESET_PC);
        stepIdle(1'b1);
        checkVal("valid after 1", 32'(instr_validF), 32'd0);
        stepIdle(1'b1);
        checkVal("valid after 2", 32'(instr_validF), 32'd1);
        checkVal("first pcF", pcF, RESET_PC);
        checkVal("first instr", instrF, memWord(RESET_PC));

        // Four sequential words, one every 3 cycles.
        for (int w = 0; w < 4; w++) begin
            n = 0;
            do begin
                stepIdle(1'b0);
                n++;
            end while (instr_validF !== 1'b1 && n < 10);
            checkVal("seq pcF", pcF, RESET_PC + 32'(4 * w));
            checkVal("seq instr", instrF, memWord(RESET_PC + 32'(4 * w)));
            if (w > 0) checkVal("seq spacing", 32'(n), 32'd3);
        end

        // Stall in HOLD for 5 cycles, then advance by 4.
        waitValid("stall wait", 10);
        for (int k = 0; k < 5; k++) begin
            stepIdle(1'b1);
            checkVal("stall pcF", pcF, RESET_PC + 32'h10);
            checkVal("stall instr", instrF, memWord(RESET_PC + 32'h10));
            checkVal("stall valid", 32'(instr_validF), 32'd1);
            checkVal("stall req", 32'(imem.inst_req), 32'd0);
        end
        stepIdle(1'b0);
        waitValid("after stall", 10);
        checkVal("after stall pcF", pcF, RESET_PC + 32'h14);

        // Jump while the fetch is in WAIT; data arrives 3 cycles after accept.
        dataLo = 2; dataHi = 2;
        n = 0;
        do begin
            stepIdle(1'b0);
            n++;
        end while (!lastAddrOk && n < 10);
        checkVal("accept seen", 32'(lastAddrOk), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_1000);
        sawValid = 1'b0;
        n = 0;
        do begin
            stepIdle(1'b1);
            if (instr_validF === 1'b1) sawValid = 1'b1;
            n++;
        end while (imem.inst_req !== 1'b1 && n < 10);
        checkVal("stale never valid", 32'(sawValid), 32'd0);
        checkVal("jump req", 32'(imem.inst_req), 32'd1);
        checkVal("jump addr", imem.inst_addr, 32'h0000_1000);
        waitValid("jump wait", 10);
        checkVal("jump instr", instrF, memWord(32'h0000_1000));

        // Branch and jump together: jump wins; ignored while stalled.
        dataLo = 0; dataHi = 0;
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 32'h300);
        stepIdle(1'b1);
        checkVal("stalled redirect pcF", pcF, 32'h0000_1000);
        checkVal("stalled redirect valid", 32'(instr_validF), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h300);
        stepIdle(1'b1);
        checkVal("both req", 32'(imem.inst_req), 32'd1);
        checkVal("both addr", imem.inst_addr, 32'h300);

        // Wait counter across one fetch with delayed handshakes.
        addrLo = 2; addrHi = 2; dataLo = 2; dataHi = 2;
        waitValid("cnt wait0", 20);
        c0 = fetchWaitCnt;
        stepIdle(1'b0);
        waitValid("cnt wait1", 20);
`ifdef FETCH_PERF_CNT_EN
        checkVal("cnt per fetch", fetchWaitCnt - c0, 32'd6);
`else
        checkVal("cnt per fetch", fetchWaitCnt - c0, 32'd0);
`endif

        // Randomized traffic against the model.
        addrLo = 0; addrHi = 2; dataLo = 0; dataHi = 3;
        for (int i = 0; i < 600; i++) begin
            tgtA = {$urandom_range(255, 0), 2'b00};
            tgtB = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF8 : {$urandom_range(1023, 0), 2'b00};
            step($urandom_range(99, 0) < 1,
                 $urandom_range(99, 0) < 25,
                 $urandom_range(99, 0) < 8,
                 $urandom_range(99, 0) < 6,
                 tgtA, tgtB);
        end
        stepIdle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
